// File: rtl/fir_decimate_by2.sv
// 16-tap low-pass FIR with decimate-by-2 for the microphone path.
// Every second accepted sample launches a 16-cycle sequential MAC.
//
// Ports:
//   clk_in             system clock
//   rst_in             synchronous active-high reset
//   audio_in           signed input sample (WIDTH bits)
//   audio_sample_valid single-cycle strobe, audio_in valid this cycle
//   dec_output         signed decimated sample, held between updates
//   dec_output_ready   single-cycle strobe, dec_output updated this cycle
module fir_decimate_by2 #(
    parameter int WIDTH = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic signed [WIDTH-1:0] audio_in,
    input  logic                    audio_sample_valid,
    output logic signed [WIDTH-1:0] dec_output,
    output logic                    dec_output_ready
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_OUT
    } state_t;

    localparam logic signed [31:0] SAT_MAX = (32'sd1 <<< (WIDTH - 1)) - 32'sd1;
    localparam logic signed [31:0] SAT_MIN = -(32'sd1 <<< (WIDTH - 1));

    state_t state;
    state_t state_nxt;

    logic signed [WIDTH-1:0] taps [16];
    logic                    phase;
    logic [3:0]              tap_idx;
    logic signed [31:0]      acc;

    logic                    accept;
    logic                    start;
    logic signed [7:0]       coef;
    logic signed [WIDTH-1:0] tap_sample;
    logic signed [31:0]      coef_ext;
    logic signed [31:0]      samp_ext;
    logic signed [31:0]      product;
    logic signed [31:0]      acc_shr;
    logic signed [WIDTH-1:0] result;

    function automatic logic signed [7:0] coef_at(input logic [3:0] k);
        unique case (k)
            4'd0:  coef_at = -8'sd2;
            4'd1:  coef_at = -8'sd6;
            4'd2:  coef_at = -8'sd4;
            4'd3:  coef_at = 8'sd12;
            4'd4:  coef_at = 8'sd36;
            4'd5:  coef_at = 8'sd48;
            4'd6:  coef_at = 8'sd76;
            4'd7:  coef_at = 8'sd96;
            4'd8:  coef_at = 8'sd96;
            4'd9:  coef_at = 8'sd76;
            4'd10: coef_at = 8'sd48;
            4'd11: coef_at = 8'sd36;
            4'd12: coef_at = 8'sd12;
            4'd13: coef_at = -8'sd4;
            4'd14: coef_at = -8'sd6;
            4'd15: coef_at = -8'sd2;
        endcase
    endfunction

    // Samples are only taken while idle; the busy window drops them.
    assign accept = (state == ST_IDLE) && audio_sample_valid;
    assign start  = accept && phase;

    always_comb begin
        coef       = coef_at(tap_idx);
        tap_sample = taps[tap_idx];
        coef_ext   = {{24{coef[7]}}, coef};
        samp_ext   = {{(32 - WIDTH){tap_sample[WIDTH-1]}}, tap_sample};
        product    = coef_ext * samp_ext;
    end

    // Floor scaling by 512 (coefficient sum), then clip to the sample range.
    always_comb begin
        acc_shr = acc >>> 9;
        result  = acc_shr[WIDTH-1:0];
        if (acc_shr > SAT_MAX) begin
            result = SAT_MAX[WIDTH-1:0];
        end else if (acc_shr < SAT_MIN) begin
            result = SAT_MIN[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_MAC;
                end
            end
            ST_MAC: begin
                if (tap_idx == 4'd15) begin
                    state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int k = 0; k < 16; k++) begin
                taps[k] <= '0;
            end
            phase            <= 1'b0;
            tap_idx          <= 4'd0;
            acc              <= 32'sd0;
            dec_output       <= '0;
            dec_output_ready <= 1'b0;
        end else begin
            dec_output_ready <= 1'b0;
            if (accept) begin
                taps[0] <= audio_in;
                for (int k = 15; k > 0; k--) begin
                    taps[k] <= taps[k-1];
                end
                phase <= ~phase;
            end
            if (start) begin
                tap_idx <= 4'd0;
                acc     <= 32'sd0;
            end
            if (state == ST_MAC) begin
                acc     <= acc + product;
                tap_idx <= tap_idx + 4'd1;
            end
            if (state == ST_OUT) begin
                dec_output       <= result;
                dec_output_ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_decimate_by2.sv
// Bench for fir_decimate_by2: directed and random stimulus against a
// sample-history reference model, plus a four-deep chain smoke test.
module tb_fir_decimate_by2;

    localparam int W = 16;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic                rst_in;
    logic signed [W-1:0] audio_in;
    logic                audio_sample_valid;
    logic signed [W-1:0] dec_output;
    logic                dec_output_ready;

    logic signed [W-1:0] o2, o3, o4;
    logic                r2, r3, r4;

    fir_decimate_by2 #(.WIDTH(W)) u_dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .audio_in(audio_in), .audio_sample_valid(audio_sample_valid),
        .dec_output(dec_output), .dec_output_ready(dec_output_ready)
    );
    fir_decimate_by2 #(.WIDTH(W)) u_s2 (
        .clk_in(clk_in), .rst_in(rst_in),
        .audio_in(dec_output), .audio_sample_valid(dec_output_ready),
        .dec_output(o2), .dec_output_ready(r2)
    );
    fir_decimate_by2 #(.WIDTH(W)) u_s3 (
        .clk_in(clk_in), .rst_in(rst_in),
        .audio_in(o2), .audio_sample_valid(r2),
        .dec_output(o3), .dec_output_ready(r3)
    );
    fir_decimate_by2 #(.WIDTH(W)) u_s4 (
        .clk_in(clk_in), .rst_in(rst_in),
        .audio_in(o3), .audio_sample_valid(r3),
        .dec_output(o4), .dec_output_ready(r4)
    );

    int errors = 0;
    int checks = 0;

    int n1, n2, n3, n4;
    always @(negedge clk_in) begin
        if (rst_in) begin
            n1 <= 0; n2 <= 0; n3 <= 0; n4 <= 0;
        end else begin
            if (dec_output_ready) n1 <= n1 + 1;
            if (r2) n2 <= n2 + 1;
            if (r3) n3 <= n3 + 1;
            if (r4) n4 <= n4 + 1;
        end
    end

    // Reference model: history of accepted samples plus timing bookkeeping.
    int     hcoef [16] = '{-2, -6, -4, 12, 36, 48, 76, 96,
                           96, 76, 48, 36, 12, -4, -6, -2};
    int     hist [16];
    bit     phase;
    longint edge_no = 0;
    longint busy_end = -1;
    bit     pend;
    longint pend_edge;
    int     pend_val;
    int     model_out;

    function automatic int model_calc();
        longint s = 0;
        for (int k = 0; k < 16; k++) s += longint'(hcoef[k]) * hist[k];
        s = s >>> 9;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return int'(s);
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit rst_now, acc_now, exp_rdy;
        int sample;
        rst_now = rst_in;
        acc_now = audio_sample_valid && !rst_in && (edge_no + 1 > busy_end);
        sample  = int'(audio_in);
        @(posedge clk_in);
        #1;
        edge_no++;
        if (rst_now) begin
            for (int k = 0; k < 16; k++) hist[k] = 0;
            phase = 0; busy_end = -1; pend = 0; model_out = 0;
        end else if (acc_now) begin
            for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = sample;
            if (phase) begin
                pend      = 1;
                pend_edge = edge_no + 17;
                pend_val  = model_calc();
                busy_end  = edge_no + 17;
            end
            phase = !phase;
        end
        exp_rdy = pend && (edge_no == pend_edge);
        if (exp_rdy) begin
            model_out = pend_val;
            pend = 0;
        end
        check("ready", {31'd0, dec_output_ready}, {31'd0, exp_rdy});
        check("dec_output", 32'(dec_output), model_out);
    endtask

    task automatic feed(input int val, input int gap);
        audio_in = W'(val);
        audio_sample_valid = 1'b1;
        tick();
        audio_sample_valid = 1'b0;
        repeat (gap - 1) tick();
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        repeat (2) tick();
        rst_in = 1'b0;
        tick();
    endtask

    int imp [9] = '{-6, 12, 48, 96, 76, 36, -4, -2, 0};

    initial begin
        rst_in = 1'b1;
        audio_in = '0;
        audio_sample_valid = 1'b0;
        do_reset();
        check("reset_out", 32'(dec_output), 0);

        // Reset in the middle of a MAC discards the result.
        feed(100, 32);
        audio_in = 16'sd200;
        audio_sample_valid = 1'b1;
        tick();
        audio_sample_valid = 1'b0;
        repeat (4) tick();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        repeat (30) tick();
        check("midmac_out", 32'(dec_output), 0);
        check("midmac_pulses", n1, 0);
        feed(512, 32);
        feed(0, 32);
        check("post_reset_first", 32'(dec_output), -6);

        // DC gain, positive then full-scale negative.
        do_reset();
        for (int i = 0; i < 40; i++) feed(256, 32);
        check("dc_pos", 32'(dec_output), 256);
        check("dc_pos_pulses", n1, 20);
        for (int i = 0; i < 40; i++) feed(-32768, 32);
        check("dc_neg", 32'(dec_output), -32768);

        // Impulse response.
        do_reset();
        feed(512, 32);
        for (int j = 0; j < 9; j++) begin
            feed(0, 32);
            feed(0, 32);
            check($sformatf("impulse_%0d", j), 32'(dec_output), imp[j]);
        end

        // Saturation both ways.
        do_reset();
        for (int k = 15; k >= 0; k--) feed(hcoef[k] > 0 ? 32767 : -32767, 32);
        check("sat_pos", 32'(dec_output), 32767);
        do_reset();
        for (int k = 15; k >= 0; k--) feed(hcoef[k] > 0 ? -32767 : 32767, 32);
        check("sat_neg", 32'(dec_output), -32768);

        // Valid inside the busy window is dropped.
        do_reset();
        feed(1000, 32);
        feed(2000, 8);
        feed(3000, 40);
        check("busy_pulses", n1, 1);
        check("busy_value", 32'(dec_output), -20);
        feed(4000, 40);
        check("busy_phase0", n1, 1);
        feed(5000, 40);
        check("busy_next", n1, 2);
        check("busy_next_value", 32'(dec_output), -59);

        // Random samples and spacing, including held and busy-window valids.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            feed(int'($signed(16'($urandom))), int'($urandom_range(1, 40)));
        end
        repeat (20) tick();

        // Chain of four stages fed the PDM '1' level.
        do_reset();
        for (int i = 0; i < 256; i++) feed(256, 32);
        repeat (200) tick();
        check("chain_s1_pulses", n1, 128);
        check("chain_s2_rate", n2, n1 / 2);
        check("chain_s3_rate", n3, n2 / 2);
        check("chain_s4_rate", n4, n3 / 2);
        check("chain_s4_out", 32'(o4), 256);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
